// File: rtl/fetch_ctrl_if.sv
// Instruction-memory fetch port: one request channel (valid/ready) and one
// response channel (valid only, in order, one fetch outstanding).
interface fetch_ctrl_if #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned ILEN = 32
);
  logic            imem_req_valid;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_req_ready;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/fetch_ctrl.sv
// PC sequencer and fetch-port controller: one fetch per PC, redirect handling
// (trap over branch), squash of in-flight fetches and a one-entry hold buffer.
module fetch_ctrl #(
  parameter int unsigned         XLEN     = 64,
  parameter int unsigned         ILEN     = 32,
  parameter logic [XLEN-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   current_pc,
  output logic [XLEN-1:0]   next_pc,
  output logic              pc_stall,
  input  logic              hazard_stall,
  input  logic              trap_valid,
  input  logic [XLEN-1:0]   trap_pc,
  input  logic              br_valid,
  input  logic [XLEN-1:0]   br_target,
  fetch_ctrl_if.master      imem,
  output logic              if_valid,
  output logic [ILEN-1:0]   if_inst,
  output logic [XLEN-1:0]   if_pc,
  output logic              if_flush
);

  typedef enum logic [2:0] {BOOT, REQ, WAIT, HOLD, DROP} state_e;

  state_e          state, state_nxt;
  logic [ILEN-1:0] hold_inst;
  logic [XLEN-1:0] hold_pc;
  logic            redirect;
  logic            deliver;
  logic            capture;
  logic [XLEN-1:0] redir_raw;
  logic [XLEN-1:0] redir_tgt;

  assign redirect  = rst && (state != BOOT) && (trap_valid || br_valid);
  assign redir_raw = trap_valid ? trap_pc : br_target;
  assign redir_tgt = {redir_raw[XLEN-1:2], 2'b00};
  assign deliver   = !redirect &&
                     (((state == WAIT) && imem.imem_rsp_valid && !hazard_stall) ||
                      ((state == HOLD) && !hazard_stall));
  assign capture   = !redirect && (state == WAIT) && imem.imem_rsp_valid && hazard_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= BOOT;
      hold_inst <= '0;
      hold_pc   <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        hold_inst <= imem.imem_rsp_data;
        hold_pc   <= current_pc;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        // an accepted old-address request must have its response squashed
        if (imem.imem_req_ready) state_nxt = redirect ? DROP : WAIT;
        else                     state_nxt = REQ;
      end
      WAIT: begin
        if (redirect)                  state_nxt = imem.imem_rsp_valid ? REQ : DROP;
        else if (imem.imem_rsp_valid)  state_nxt = hazard_stall ? HOLD : REQ;
      end
      HOLD: begin
        if (redirect || !hazard_stall) state_nxt = REQ;
      end
      DROP: begin
        if (imem.imem_rsp_valid) state_nxt = REQ;
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_comb begin
    imem.imem_req_valid = 1'b0;
    imem.imem_req_addr  = current_pc;
    if_valid            = 1'b0;
    if_inst             = (state == HOLD) ? hold_inst : imem.imem_rsp_data;
    if_pc               = (state == HOLD) ? hold_pc : current_pc;
    if_flush            = 1'b0;
    pc_stall            = 1'b1;
    next_pc             = current_pc;
    if (!rst) begin
      next_pc = RESET_PC;
    end else begin
      imem.imem_req_valid = (state == REQ);
      if (redirect) begin
        if_flush = 1'b1;
        pc_stall = 1'b0;
        next_pc  = redir_tgt;
      end else if (deliver) begin
        if_valid = 1'b1;
        pc_stall = 1'b0;
        next_pc  = current_pc + XLEN'(4);
      end
    end
  end

endmodule
